rdi_sb_msg_serializer: RTL

- Sideband transmit stage directly downstream of the RDI power-management message sources (PM entry/exit handlers).
- Accepts a 4-bit encoded message request (valid + msg_no), builds a 64-bit sideband message-without-data packet, and shifts it out LSB-first on a 1-bit serial lane with a gated-clock enable.
- Enforces the 32-cycle inter-packet idle gap, then returns a one-cycle done pulse to the requester.

---
 rtl/rdi_sb_msg_serializer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/rdi_sb_msg_serializer.sv
`default_nettype none
// ============================================================================
// Module   : rdi_sb_msg_serializer
// Purpose  : Builds a 64-bit sideband message-without-data packet for an RDI
//            power-management request and shifts it out LSB-first, followed
//            by a fixed idle gap and a one-cycle done pulse.
// Revision : 1.0  initial release
// ============================================================================
module rdi_sb_msg_serializer #(
    parameter logic [2:0] SRCID        = 3'b001,
    parameter logic [2:0] DSTID        = 3'b101,
    parameter logic [7:0] MSGCODE_BASE = 8'h10,
    parameter int         GAP_CYCLES   = 32
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_msg_valid,
    input  logic [3:0] i_msg_no,
    output logic       o_sb_data,
    output logic       o_sb_clk_en,
    output logic       o_msg_done,
    output logic       o_busy,
    output logic       o_err
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LOAD  = 3'd1;
    localparam logic [2:0] c_SHIFT = 3'd2;
    localparam logic [2:0] c_GAP   = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    localparam logic [4:0] c_OPCODE   = 5'b10010;
    localparam logic [5:0] c_BIT_LAST = 6'd63;
    localparam logic [5:0] c_GAP_LAST = 6'(GAP_CYCLES - 1);

    logic [2:0]  r_state;
    logic [5:0]  r_cnt;
    logic [3:0]  r_msg_no;
    logic [62:0] r_shreg;

    logic [7:0]  w_msgcode;
    logic [62:0] w_body;
    logic [63:0] w_header;

    always_comb begin
        w_msgcode       = MSGCODE_BASE | {4'h0, r_msg_no};
        w_body          = '0;
        w_body[4:0]     = c_OPCODE;
        w_body[21:14]   = w_msgcode;
        w_body[34:32]   = SRCID;
        w_body[45:38]   = 8'h00;
        w_body[61:59]   = DSTID;
        w_body[62]      = 1'b0;
    end

    // cp makes the XOR over the whole header even
    assign w_header = {^w_body[61:0], w_body};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_msg_no    <= '0;
            r_shreg     <= '0;
            o_sb_data   <= 1'b0;
            o_sb_clk_en <= 1'b0;
            o_msg_done  <= 1'b0;
            o_busy      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_msg_done <= 1'b0;
            o_err      <= 1'b0;
            if (!i_en) begin
                r_state     <= c_IDLE;
                r_cnt       <= '0;
                o_sb_data   <= 1'b0;
                o_sb_clk_en <= 1'b0;
                o_busy      <= 1'b0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (i_msg_valid) begin
                            if (i_msg_no != 4'h0) begin
                                r_msg_no <= i_msg_no;
                                r_state  <= c_LOAD;
                                o_busy   <= 1'b1;
                            end else begin
                                o_err <= 1'b1;
                            end
                        end
                    end
                    c_LOAD: begin
                        // bit 0 goes straight to the lane; the rest waits in the shifter
                        r_shreg     <= w_header[63:1];
                        o_sb_data   <= w_header[0];
                        o_sb_clk_en <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= c_SHIFT;
                    end
                    c_SHIFT: begin
                        if (r_cnt == c_BIT_LAST) begin
                            r_cnt       <= '0;
                            o_sb_data   <= 1'b0;
                            o_sb_clk_en <= 1'b0;
                            r_state     <= c_GAP;
                        end else begin
                            r_cnt     <= r_cnt + 6'd1;
                            o_sb_data <= r_shreg[0];
                            r_shreg   <= {1'b0, r_shreg[62:1]};
                        end
                    end
                    c_GAP: begin
                        if (r_cnt == c_GAP_LAST) begin
                            r_cnt      <= '0;
                            o_msg_done <= 1'b1;
                            r_state    <= c_DONE;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                    c_DONE: begin
                        o_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end
                    default: begin
                        r_state     <= c_IDLE;
                        r_cnt       <= '0;
                        o_sb_data   <= 1'b0;
                        o_sb_clk_en <= 1'b0;
                        o_busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
